vga_timing_sched: RTL
=====================

// Module: vga_timing_sched
// PURPOSE
//  Parametrised VGA timing generator with a built-in pixel clock-enable divider and a
//  frame-synchronous change scheduler. Drives sync/blank and scaled pixel coordinates
//  for main_logic from the system clock. Change-request levels (background, font, ...)
//  become one-clock strobes at the start of vertical blanking, so table updates never tear.
// PARAMETERS
//  CLK_DIV      4    system clocks per pixel (>=1; 1 => pix_en constantly high)
//  H_ACTIVE     640  visible pixels per line
//  H_FP,H_SYNC,H_BP  16,96,48   horizontal porches/sync, in pixels
//  V_ACTIVE     480  visible lines per frame
//  V_FP,V_SYNC,V_BP  10,2,33    vertical porches/sync, in lines
//  SYNC_POL     0    asserted level of hsync/vsync
//  SCALE_SHIFT  1    pixel_x/pixel_y = counter >> SCALE_SHIFT
//  HW,VW        10,10  horizontal/vertical counter widths
//  NUM_REQ      2    number of change-request channels
// PORTS
//  clk        in   1                system clock
//  rst        in   1                asynchronous reset, active-low
//  pix_en     out  1                one-clock pixel enable, every CLK_DIV clocks
//  hsync      out  1                horizontal sync, level SYNC_POL while asserted
//  vsync      out  1                vertical sync, level SYNC_POL while asserted
//  comp_sync  out  1                low while hsync or vsync asserted, else high
//  blank      out  1                1 outside the active area
//  pixel_x    out  HW-SCALE_SHIFT   scaled column; holds last value during h-blank
//  pixel_y    out  VW-SCALE_SHIFT   scaled row; holds last value during v-blank
//  frame_cnt  out  8                frames completed, wraps 255->0
//  chg_req    in   NUM_REQ          per-channel request level (bchange/fchange style)
//  chg_strobe out  NUM_REQ          one-clock update strobe per channel
//  chg_pend   out  NUM_REQ          request captured, strobe not yet issued
// BEHAVIOUR
//  Reset (rst=0, async):
//   div_cnt, hcnt, vcnt, pixel_x, pixel_y, frame_cnt = 0; pix_en, blank, chg_strobe, chg_pend = 0.
//   hsync, vsync = ~SYNC_POL; comp_sync = 1. chg_req edge-history regs = 0.
//  Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_en is registered and high on the
//   clock where div_cnt==CLK_DIV-1.
//  Counters: on each clock with pix_en=1, hcnt increments, wrapping at
//   HT=H_ACTIVE+H_FP+H_SYNC+H_BP. On hcnt wrap, vcnt increments, wrapping at VT (same form).
//   On vcnt wrap, frame_cnt increments.
//  Outputs: registered decode of the NEW hcnt/vcnt, updated on the same edge, so each
//   value is stable for CLK_DIV clocks.
//   hsync asserted for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC; vsync likewise on vcnt.
//   blank = (hcnt>=H_ACTIVE)|(vcnt>=V_ACTIVE).
//   pixel_x/pixel_y load only while the counter is in the active range.
//  Scheduler (per channel i):
//   rising edge of chg_req[i] (registered compare) sets chg_pend[i].
//   Vblank start = pix_en cycle in which the counters advance to hcnt==0, vcnt==V_ACTIVE.
//   On that cycle, chg_strobe[i] pulses for exactly one clk for every set chg_pend[i],
//   and those chg_pend bits clear.
//   Rising edge coincident with the vblank-start cycle: not served; chg_pend[i] is set
//   after the cycle, and the strobe is issued at the next frame's vblank start.
//   Extra rising edges while pending merge into the single pending bit (one strobe).
//   A level held high produces one strobe only.
//  Reset mid-frame: everything returns to reset values at once; pending requests are
//   dropped; the first frame after release is full length.
//  Width rule: HW/VW must hold HT-1/VT-1. No saturation; counters use explicit compare-wrap.
// TESTING
//  T1 defaults, 2 frames: pix_en period 4 clks; hsync low 384 clks per 3200-clk line;
//   vsync low 2 lines; frame = 1,680,000 clks.
//  T2 pixel_x at hcnt=639 is 319, held at 319 through h-blank; pixel_y at vcnt=479 is 239;
//   blank rises on hcnt=640.
//  T3 chg_req[0] pulse at line 100 -> chg_pend[0]=1 until vblank start; one chg_strobe[0]
//   on the hcnt=0/vcnt=480 edge; then pend=0.
//  T4 chg_req[1] rising on the vblank-start clk and chg_req[0] earlier:
//   strobe[0] this frame, strobe[1] next frame only; frame_cnt increments once per frame.
//  T5 rst low at line 300 with chg_pend=2'b11 -> all outputs at reset values
//   asynchronously; no strobe after release; hsync first asserts after 656 pixels.
//  T6 CLK_DIV=1, H 8/1/2/1, V 4/1/1/1, SYNC_POL=1: pix_en constantly 1; line = 12 clks;
//   frame = 84 clks; hsync high at hcnt=9,10.

Source files
------------

// File: rtl/vga_timing_sched_if.sv
// VGA timing/scheduler bundle: sync, blank, scaled coordinates, frame count, change requests.
// Latency: none; this file only groups wires.
// Backpressure: none; outputs are free-running, and requests are levels sampled every clock.
interface vga_timing_sched_if #(
   parameter int HW          = 10,
   parameter int VW          = 10,
   parameter int SCALE_SHIFT = 1,
   parameter int NUM_REQ     = 2
);
   logic                      pix_en;
   logic                      hsync;
   logic                      vsync;
   logic                      comp_sync;
   logic                      blank;
   logic [HW-SCALE_SHIFT-1:0] pixel_x;
   logic [VW-SCALE_SHIFT-1:0] pixel_y;
   logic [7:0]                frame_cnt;
   logic [NUM_REQ-1:0]        chg_req;
   logic [NUM_REQ-1:0]        chg_strobe;
   logic [NUM_REQ-1:0]        chg_pend;

   // The timing generator drives everything except the request levels.
   modport master (
      output pix_en, hsync, vsync, comp_sync, blank, pixel_x, pixel_y, frame_cnt,
      output chg_strobe, chg_pend,
      input  chg_req
   );

   // The consumer (main_logic) raises requests and watches the timing outputs.
   modport slave (
      input  pix_en, hsync, vsync, comp_sync, blank, pixel_x, pixel_y, frame_cnt,
      input  chg_strobe, chg_pend,
      output chg_req
   );
endinterface

// File: rtl/vga_timing_sched.sv
// VGA timing generator with a pixel clock-enable divider and a frame-synchronous change scheduler.
// Latency: outputs are registered decodes of the counters after each advance; strobes fire on the vblank-start edge.
// Backpressure: none; the generator free-runs, and requests stay pending until the next vblank start.
module vga_timing_sched #(
   parameter int CLK_DIV     = 4,
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter bit SYNC_POL    = 1'b0,
   parameter int SCALE_SHIFT = 1,
   parameter int HW          = 10,
   parameter int VW          = 10,
   parameter int NUM_REQ     = 2
) (
   input  logic                i_clk,
   input  logic                i_rst,
   vga_timing_sched_if.master  io_vga
);
   localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int PXW = HW - SCALE_SHIFT;
   localparam int PYW = VW - SCALE_SHIFT;

   localparam logic [DW-1:0] L_DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [HW-1:0] L_H_LAST   = HW'(HT - 1);
   localparam logic [VW-1:0] L_V_LAST   = VW'(VT - 1);
   localparam logic [VW-1:0] L_V_ACT    = VW'(V_ACTIVE);

   logic [DW-1:0]      r_div_cnt;
   logic               r_pix_en;
   logic [HW-1:0]      r_hcnt;
   logic [VW-1:0]      r_vcnt;
   logic               r_hsync;
   logic               r_vsync;
   logic               r_comp_sync;
   logic               r_blank;
   logic [PXW-1:0]     r_pixel_x;
   logic [PYW-1:0]     r_pixel_y;
   logic [7:0]         r_frame_cnt;
   logic [NUM_REQ-1:0] r_req_q;
   logic [NUM_REQ-1:0] r_strobe;
   logic [NUM_REQ-1:0] r_pend;

   logic [DW-1:0]      w_div_nxt;
   logic               w_h_wrap;
   logic               w_v_wrap;
   logic [HW-1:0]      w_h_nxt;
   logic [VW-1:0]      w_v_nxt;
   logic [31:0]        w_hn;
   logic [31:0]        w_vn;
   logic               w_hs_act;
   logic               w_vs_act;
   logic               w_h_act;
   logic               w_v_act;
   logic               w_f_inc;
   logic               w_vbs;
   logic [NUM_REQ-1:0] w_rise;

   assign w_div_nxt = (r_div_cnt == L_DIV_LAST) ? '0 : r_div_cnt + DW'(1);

   // Next counter values; they only move on a pixel-enable clock.
   assign w_h_wrap = (r_hcnt == L_H_LAST);
   assign w_v_wrap = (r_vcnt == L_V_LAST);
   assign w_h_nxt  = !r_pix_en ? r_hcnt : (w_h_wrap ? '0 : r_hcnt + HW'(1));
   assign w_v_nxt  = !(r_pix_en && w_h_wrap) ? r_vcnt : (w_v_wrap ? '0 : r_vcnt + VW'(1));
   assign w_f_inc  = r_pix_en && w_h_wrap && w_v_wrap;

   // Output decode looks at the new counter values so the outputs line up with the counters.
   assign w_hn     = 32'(w_h_nxt);
   assign w_vn     = 32'(w_v_nxt);
   assign w_hs_act = (w_hn >= 32'(H_ACTIVE + H_FP)) && (w_hn < 32'(H_ACTIVE + H_FP + H_SYNC));
   assign w_vs_act = (w_vn >= 32'(V_ACTIVE + V_FP)) && (w_vn < 32'(V_ACTIVE + V_FP + V_SYNC));
   assign w_h_act  = (w_hn < 32'(H_ACTIVE));
   assign w_v_act  = (w_vn < 32'(V_ACTIVE));

   // Vblank start: this pixel step lands on column 0 of the first blanked line.
   assign w_vbs    = r_pix_en && w_h_wrap && (w_v_nxt == L_V_ACT);
   assign w_rise   = io_vga.chg_req & ~r_req_q;

   // Pixel-enable divider; pix_en is high while the divider sits on its last count.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_div_cnt <= '0;
         r_pix_en  <= 1'b0;
      end else begin
         r_div_cnt <= w_div_nxt;
         r_pix_en  <= (w_div_nxt == L_DIV_LAST);
      end
   end

   // Horizontal, vertical and frame counters.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_hcnt      <= '0;
         r_vcnt      <= '0;
         r_frame_cnt <= '0;
      end else begin
         r_hcnt <= w_h_nxt;
         r_vcnt <= w_v_nxt;
         if (w_f_inc) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end
      end
   end

   // Registered sync/blank decode; the coordinates hold their last active value through blanking.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_hsync     <= ~SYNC_POL;
         r_vsync     <= ~SYNC_POL;
         r_comp_sync <= 1'b1;
         r_blank     <= 1'b0;
         r_pixel_x   <= '0;
         r_pixel_y   <= '0;
      end else begin
         r_hsync     <= w_hs_act ? SYNC_POL : ~SYNC_POL;
         r_vsync     <= w_vs_act ? SYNC_POL : ~SYNC_POL;
         r_comp_sync <= ~(w_hs_act | w_vs_act);
         r_blank     <= ~(w_h_act & w_v_act);
         if (w_h_act) begin
            r_pixel_x <= w_h_nxt[HW-1:SCALE_SHIFT];
         end
         if (w_v_act) begin
            r_pixel_y <= w_v_nxt[VW-1:SCALE_SHIFT];
         end
      end
   end

   // Change scheduler: capture rising edges, release them as one strobe per channel at vblank start.
   // An edge arriving on the vblank-start clock becomes pending and is served one frame later.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_req_q  <= '0;
         r_strobe <= '0;
         r_pend   <= '0;
      end else begin
         r_req_q  <= io_vga.chg_req;
         r_strobe <= w_vbs ? r_pend : '0;
         r_pend   <= (w_vbs ? '0 : r_pend) | w_rise;
      end
   end

   assign io_vga.pix_en     = r_pix_en;
   assign io_vga.hsync      = r_hsync;
   assign io_vga.vsync      = r_vsync;
   assign io_vga.comp_sync  = r_comp_sync;
   assign io_vga.blank      = r_blank;
   assign io_vga.pixel_x    = r_pixel_x;
   assign io_vga.pixel_y    = r_pixel_y;
   assign io_vga.frame_cnt  = r_frame_cnt;
   assign io_vga.chg_strobe = r_strobe;
   assign io_vga.chg_pend   = r_pend;
endmodule
